// File: rtl/q_stream_tx_pkg.sv
// Shared neuron-side definitions for the Q streaming transmitter:
// default widths and the transfer FSM state encoding.
package q_stream_tx_pkg;

  localparam int Q_ADDR_WIDTH_DEF = 10;
  localparam int Q_DATA_WIDTH_DEF = 2;
  localparam int WORD_WIDTH_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/q_stream_tx_if.sv
// Host-side word stream, transfer control and neuron Q write port of q_stream_tx.
interface q_stream_tx_if
  import q_stream_tx_pkg::*;
#(
  parameter int Q_ADDR_WIDTH = Q_ADDR_WIDTH_DEF,
  parameter int Q_DATA_WIDTH = Q_DATA_WIDTH_DEF,
  parameter int WORD_WIDTH   = WORD_WIDTH_DEF
);

  logic                    start;
  logic [Q_ADDR_WIDTH:0]   num_entries;
  logic [WORD_WIDTH-1:0]   word_in;
  logic                    word_valid;
  logic                    word_ready;
  logic                    wrQ;
  logic [Q_DATA_WIDTH-1:0] Q_in;
  logic                    busy;
  logic                    done;

  modport master (
    output start, num_entries, word_in, word_valid,
    input  word_ready, wrQ, Q_in, busy, done
  );

  modport slave (
    input  start, num_entries, word_in, word_valid,
    output word_ready, wrQ, Q_in, busy, done
  );

endinterface

// File: rtl/q_word_unpacker.sv
// Splits host words into Q entries LSB-first: an active shift register that is
// drained one entry per emit, backed by a one-word prefetch holding register.
module q_word_unpacker
  import q_stream_tx_pkg::*;
#(
  parameter int Q_DATA_WIDTH = Q_DATA_WIDTH_DEF,
  parameter int WORD_WIDTH   = WORD_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic                    clr,
  input  logic                    emit_en,
  input  logic                    accept,
  input  logic [WORD_WIDTH-1:0]   word_in,
  output logic                    hold_free,
  output logic                    emit,
  output logic [Q_DATA_WIDTH-1:0] entry
);

  localparam int EPW   = WORD_WIDTH / Q_DATA_WIDTH;
  localparam int CNT_W = $clog2(EPW + 1);

  logic [WORD_WIDTH-1:0] act_q, act_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [WORD_WIDTH-1:0] src;
  logic [CNT_W-1:0]      src_cnt;
  logic                  act_empty;
  logic                  direct;

  // idx_q counts entries still waiting in the active register.
  assign act_empty = (idx_q == '0);

  // When the active word runs dry, the next entry comes from the holding
  // register, or straight from the bus so a fresh word emits with 1-cycle latency.
  always_comb begin
    src     = act_q;
    src_cnt = idx_q;
    if (act_empty) begin
      src     = hold_vld_q ? hold_q : word_in;
      src_cnt = CNT_W'(EPW);
    end
  end

  assign emit      = emit_en & (~act_empty | hold_vld_q | accept);
  assign direct    = emit & act_empty & ~hold_vld_q;
  assign hold_free = ~hold_vld_q | (emit_en & act_empty);
  assign entry     = src[Q_DATA_WIDTH-1:0];

  always_comb begin
    act_d      = act_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (clr) begin
      idx_d      = '0;
      hold_vld_d = 1'b0;
    end else begin
      if (emit) begin
        act_d = src >> Q_DATA_WIDTH;
        idx_d = src_cnt - CNT_W'(1);
      end
      if (accept && !direct) begin
        hold_d     = word_in;
        hold_vld_d = 1'b1;
      end else if (emit && act_empty) begin
        hold_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      act_q      <= '0;
      hold_q     <= '0;
      idx_q      <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      act_q      <= act_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      hold_vld_q <= hold_vld_d;
    end
  end

endmodule

// File: rtl/q_stream_tx.sv
// Streams packed host words into the neuron Q RAM as one registered wrQ/Q_in
// write per entry; FSM, entry and word counters live here.
module q_stream_tx
  import q_stream_tx_pkg::*;
#(
  parameter int Q_ADDR_WIDTH = Q_ADDR_WIDTH_DEF,
  parameter int Q_DATA_WIDTH = Q_DATA_WIDTH_DEF,
  parameter int WORD_WIDTH   = WORD_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         reset_l,
  q_stream_tx_if.slave bus
);

  localparam int EPW = WORD_WIDTH / Q_DATA_WIDTH;
  localparam int CW  = Q_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_N = CW'(1) << Q_ADDR_WIDTH;

  function automatic logic [CW-1:0] sat_entries(input logic [CW-1:0] n);
    return (n > MAX_N) ? MAX_N : n;
  endfunction

  // One extra bit keeps the ceil rounding from overflowing at MAX_N.
  function automatic logic [CW-1:0] words_for(input logic [CW-1:0] n);
    logic [CW:0] t;
    t = {1'b0, n} + (CW+1)'(EPW - 1);
    return CW'(t / (CW+1)'(EPW));
  endfunction

  state_t                  state_q, state_d;
  logic [CW-1:0]           rem_q, rem_d;
  logic [CW-1:0]           wleft_q, wleft_d;
  logic                    wrq_q, wrq_d;
  logic [Q_DATA_WIDTH-1:0] q_in_q, q_in_d;
  logic                    run;
  logic                    start_acc;
  logic                    accept;
  logic                    emit_en;
  logic                    emit;
  logic                    hold_free;
  logic [Q_DATA_WIDTH-1:0] entry;

  assign run       = (state_q == ST_RUN);
  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign emit_en   = run && (rem_q != '0);
  assign accept    = bus.word_ready && bus.word_valid;

  assign bus.word_ready = run && hold_free && (wleft_q != '0);
  assign bus.wrQ        = wrq_q;
  assign bus.Q_in       = q_in_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_FINISH);

  q_word_unpacker #(
    .Q_DATA_WIDTH(Q_DATA_WIDTH),
    .WORD_WIDTH  (WORD_WIDTH)
  ) u_unpack (
    .clk      (clk),
    .reset_l  (reset_l),
    .clr      (start_acc),
    .emit_en  (emit_en),
    .accept   (accept),
    .word_in  (bus.word_in),
    .hold_free(hold_free),
    .emit     (emit),
    .entry    (entry)
  );

  // RUN exits once rem_q hits zero, which is the cycle the last wrQ is visible,
  // so done follows that write by exactly one cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wleft_d = wleft_q;
    wrq_d   = emit;
    q_in_d  = emit ? entry : q_in_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          rem_d   = sat_entries(bus.num_entries);
          wleft_d = words_for(sat_entries(bus.num_entries));
        end
      end
      ST_RUN: begin
        if (rem_q == '0) state_d = ST_FINISH;
        if (emit) rem_d = rem_q - CW'(1);
        if (accept) wleft_d = wleft_q - CW'(1);
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      wleft_q <= '0;
      wrq_q   <= 1'b0;
      q_in_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wleft_q <= wleft_d;
      wrq_q   <= wrq_d;
      q_in_q  <= q_in_d;
    end
  end

endmodule

// File: tb/tb_q_stream_tx.sv
// Directed bench for q_stream_tx: one task per scenario, expected values
// derived from the chosen stimulus words and the start-relative cycle timing.
module tb_q_stream_tx;

  logic clk;
  logic reset_l;
  int   total;
  int   bad;

  q_stream_tx_if #(.Q_ADDR_WIDTH(10), .Q_DATA_WIDTH(2), .WORD_WIDTH(32)) bus ();

  q_stream_tx #(.Q_ADDR_WIDTH(10), .Q_DATA_WIDTH(2), .WORD_WIDTH(32)) dut (
    .clk    (clk),
    .reset_l(reset_l),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] word_mem [0:63];
  logic [1:0]  got [0:1199];
  int wr_cnt, hs_cnt, done_cnt, done_cyc, ready_seen, held_err, gap_cnt, busy_t1, timeout;

  // Start a transfer at cycle 0 and run the upstream side cycle by cycle,
  // recording what the neuron side sees. Cycle t is the t-th cycle after start.
  task automatic drive_xfer(input int n, input int nwords, input int stall_lo,
                            input int stall_hi, input int extra_t, input int max_cyc);
    bit         acc;
    int         widx;
    int         last_wr;
    logic [1:0] last_q;
    acc = 0; widx = 0; last_wr = -1; last_q = '0;
    wr_cnt = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; ready_seen = 0;
    held_err = 0; gap_cnt = 0; busy_t1 = 0;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_entries = 11'(n);
    bus.word_valid  = 1'b0;
    for (int t = 1; t <= max_cyc; t++) begin
      @(negedge clk);
      if (acc) begin
        widx++;
        hs_cnt++;
      end
      if (t == 1) busy_t1 = int'(bus.busy);
      if (bus.wrQ) begin
        if (wr_cnt < 1200) got[wr_cnt] = bus.Q_in;
        if (last_wr >= 0 && t - last_wr > 1) gap_cnt += t - last_wr - 1;
        wr_cnt++;
        last_wr = t;
        last_q  = bus.Q_in;
      end else if (wr_cnt > 0 && bus.Q_in !== last_q) begin
        held_err++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = t;
      end
      if (bus.word_ready) ready_seen++;
      bus.start       = (t == extra_t);
      bus.num_entries = (t == extra_t) ? 11'd5 : 11'(n);
      bus.word_valid  = (widx < nwords) && !(t >= stall_lo && t < stall_hi);
      bus.word_in     = word_mem[(widx < 64) ? widx : 63];
      acc = bus.word_valid && bus.word_ready;
      if (done_cyc >= 0 && t >= done_cyc + 3) break;
    end
    timeout = (done_cyc < 0) ? 1 : 0;
    bus.start      = 1'b0;
    bus.word_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_l        = 1'b0;
    bus.start      = 1'b0;
    bus.word_valid = 1'b1;
    bus.word_in    = 32'hFFFF_FFFF;
    bus.num_entries = 11'd5;
    repeat (3) @(negedge clk);
    total++; if (bus.wrQ !== 1'b0) begin bad++; $display("FAIL rst_wrQ got=%b exp=0", bus.wrQ); end
    total++; if (bus.Q_in !== 2'd0) begin bad++; $display("FAIL rst_Q_in got=%0d exp=0", bus.Q_in); end
    total++; if (bus.word_ready !== 1'b0) begin bad++; $display("FAIL rst_word_ready got=%b exp=0", bus.word_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    reset_l = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.word_ready !== 1'b0) begin bad++; $display("FAIL idle_word_ready got=%b exp=0", bus.word_ready); end
    total++; if (bus.wrQ !== 1'b0) begin bad++; $display("FAIL idle_wrQ got=%b exp=0", bus.wrQ); end
    bus.word_valid = 1'b0;
  endtask

  task automatic test_contig();
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 16; k++)
        word_mem[w][k*2 +: 2] = 2'((16*w + k) % 3);
    drive_xfer(64, 4, 0, 0, -1, 200);
    total++; if (timeout !== 0) begin bad++; $display("FAIL contig_timeout got=%0d exp=0", timeout); end
    total++; if (busy_t1 !== 1) begin bad++; $display("FAIL contig_busy got=%0d exp=1", busy_t1); end
    total++; if (wr_cnt !== 64) begin bad++; $display("FAIL contig_wr got=%0d exp=64", wr_cnt); end
    total++; if (gap_cnt !== 0) begin bad++; $display("FAIL contig_gap got=%0d exp=0", gap_cnt); end
    total++; if (hs_cnt !== 4) begin bad++; $display("FAIL contig_hs got=%0d exp=4", hs_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL contig_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (done_cyc !== 66) begin bad++; $display("FAIL contig_done_cyc got=%0d exp=66", done_cyc); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got[i] !== 2'(i % 3)) begin
        bad++; $display("FAIL contig_data[%0d] got=%0d exp=%0d", i, got[i], i % 3);
      end
    end
  endtask

  task automatic test_partial();
    logic [1:0] exp;
    word_mem[0] = 32'hE4E4_1B1B;
    word_mem[1] = 32'h9C3A_65F0;
    word_mem[2] = 32'hFFFF_FFFF;
    word_mem[3] = 32'hFFFF_FFFF;
    drive_xfer(20, 4, 0, 0, -1, 100);
    total++; if (timeout !== 0) begin bad++; $display("FAIL partial_timeout got=%0d exp=0", timeout); end
    total++; if (wr_cnt !== 20) begin bad++; $display("FAIL partial_wr got=%0d exp=20", wr_cnt); end
    total++; if (hs_cnt !== 2) begin bad++; $display("FAIL partial_hs got=%0d exp=2", hs_cnt); end
    total++; if (done_cyc !== 22) begin bad++; $display("FAIL partial_done_cyc got=%0d exp=22", done_cyc); end
    for (int i = 0; i < 20; i++) begin
      exp = word_mem[i/16][(i%16)*2 +: 2];
      total++;
      if (got[i] !== exp) begin bad++; $display("FAIL partial_data[%0d] got=%0d exp=%0d", i, got[i], exp); end
    end
  endtask

  task automatic test_starve();
    logic [1:0] exp;
    word_mem[0] = 32'h1234_5678;
    word_mem[1] = 32'hCAFE_F00D;
    drive_xfer(32, 2, 2, 25, -1, 200);
    total++; if (timeout !== 0) begin bad++; $display("FAIL starve_timeout got=%0d exp=0", timeout); end
    total++; if (wr_cnt !== 32) begin bad++; $display("FAIL starve_wr got=%0d exp=32", wr_cnt); end
    total++; if (gap_cnt !== 8) begin bad++; $display("FAIL starve_gap got=%0d exp=8", gap_cnt); end
    total++; if (held_err !== 0) begin bad++; $display("FAIL starve_held got=%0d exp=0", held_err); end
    total++; if (done_cyc !== 42) begin bad++; $display("FAIL starve_done_cyc got=%0d exp=42", done_cyc); end
    for (int i = 0; i < 32; i++) begin
      exp = word_mem[i/16][(i%16)*2 +: 2];
      total++;
      if (got[i] !== exp) begin bad++; $display("FAIL starve_data[%0d] got=%0d exp=%0d", i, got[i], exp); end
    end
  endtask

  task automatic test_zero();
    drive_xfer(0, 4, 0, 0, -1, 20);
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL zero_wr got=%0d exp=0", wr_cnt); end
    total++; if (ready_seen !== 0) begin bad++; $display("FAIL zero_ready got=%0d exp=0", ready_seen); end
    total++; if (done_cyc !== 2) begin bad++; $display("FAIL zero_done_cyc got=%0d exp=2", done_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int         cnt;
    int         late;
    logic [1:0] exp;
    for (int w = 0; w < 4; w++) word_mem[w] = 32'h2492_4924;
    cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.num_entries = 11'd64;
    @(negedge clk);
    bus.start = 1'b0; bus.word_valid = 1'b1; bus.word_in = word_mem[0];
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.wrQ) cnt++;
      if (cnt == 10) break;
    end
    total++; if (cnt !== 10) begin bad++; $display("FAIL rmid_reach got=%0d exp=10", cnt); end
    reset_l = 1'b0;
    #1;
    total++; if (bus.wrQ !== 1'b0) begin bad++; $display("FAIL rmid_wrQ got=%b exp=0", bus.wrQ); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.Q_in !== 2'd0) begin bad++; $display("FAIL rmid_Q_in got=%0d exp=0", bus.Q_in); end
    @(negedge clk);
    reset_l = 1'b1;
    late = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.wrQ || bus.word_ready) late++;
    end
    total++; if (late !== 0) begin bad++; $display("FAIL rmid_after got=%0d exp=0", late); end
    bus.word_valid = 1'b0;
    word_mem[0] = 32'h0F0F_3C3C;
    drive_xfer(16, 1, 0, 0, -1, 100);
    total++; if (wr_cnt !== 16) begin bad++; $display("FAIL rmid_new_wr got=%0d exp=16", wr_cnt); end
    total++; if (done_cyc !== 18) begin bad++; $display("FAIL rmid_new_done got=%0d exp=18", done_cyc); end
    for (int i = 0; i < 16; i++) begin
      exp = word_mem[0][i*2 +: 2];
      total++;
      if (got[i] !== exp) begin bad++; $display("FAIL rmid_data[%0d] got=%0d exp=%0d", i, got[i], exp); end
    end
  endtask

  task automatic test_restart_ignored();
    for (int w = 0; w < 3; w++) word_mem[w] = 32'hA5C3_0F96 ^ (32'h1111_1111 * w);
    drive_xfer(48, 3, 0, 0, 10, 200);
    total++; if (wr_cnt !== 48) begin bad++; $display("FAIL restart_wr got=%0d exp=48", wr_cnt); end
    total++; if (done_cyc !== 50) begin bad++; $display("FAIL restart_done_cyc got=%0d exp=50", done_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (hs_cnt !== 3) begin bad++; $display("FAIL restart_hs got=%0d exp=3", hs_cnt); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp;
    int         errs;
    for (int w = 0; w < 64; w++) word_mem[w] = (32'h0103_0507 * w) ^ 32'h5A5A_5A5A;
    drive_xfer(2047, 64, 0, 0, -1, 1200);
    total++; if (timeout !== 0) begin bad++; $display("FAIL sat_timeout got=%0d exp=0", timeout); end
    total++; if (wr_cnt !== 1024) begin bad++; $display("FAIL sat_wr got=%0d exp=1024", wr_cnt); end
    total++; if (hs_cnt !== 64) begin bad++; $display("FAIL sat_hs got=%0d exp=64", hs_cnt); end
    total++; if (done_cyc !== 1026) begin bad++; $display("FAIL sat_done_cyc got=%0d exp=1026", done_cyc); end
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      exp = word_mem[i/16][(i%16)*2 +: 2];
      if (got[i] !== exp) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL sat_data got=%0d wrong entries exp=0", errs); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_l         = 1'b0;
    bus.start       = 1'b0;
    bus.num_entries = '0;
    bus.word_in     = '0;
    bus.word_valid  = 1'b0;
    test_reset();
    test_contig();
    test_partial();
    test_starve();
    test_zero();
    test_reset_mid();
    test_restart_ignored();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
